// File: rtl/clint_arbiter_pkg.sv
`default_nettype none
// clint_pkg -- shared state encoding, defaults and CLINT register map for clint_arbiter (rev 1.0)
package clint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int CLINT_TIMEOUT_DEFAULT = 255;

  localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
  localparam logic [31:0] MTIME_BASE    = 32'h0000_BFF8;

  // Index width that stays legal when only one requester exists
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clint_arbiter_if.sv
`default_nettype none
// clint_arbiter_if -- requester-side and CLINT-side buses of the arbiter (rev 1.0)
interface clint_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_REQ  = 2
) ();

  logic [N_REQ-1:0]            s_valid;
  logic [N_REQ*ADDR_W-1:0]     s_address;
  logic [N_REQ*DATA_W-1:0]     s_wdata;
  logic [N_REQ*(DATA_W/8)-1:0] s_wstrb;
  logic [N_REQ*DATA_W-1:0]     s_rdata;
  logic [N_REQ-1:0]            s_ready;
  logic [N_REQ-1:0]            s_err;

  logic                        m_valid;
  logic [ADDR_W-1:0]           m_address;
  logic [DATA_W-1:0]           m_wdata;
  logic [DATA_W/8-1:0]         m_wstrb;
  logic [DATA_W-1:0]           m_rdata;
  logic                        m_ready;

  modport slave (
    input  s_valid, s_address, s_wdata, s_wstrb,
    output s_rdata, s_ready, s_err,
    output m_valid, m_address, m_wdata, m_wstrb,
    input  m_rdata, m_ready
  );

  modport master (
    output s_valid, s_address, s_wdata, s_wstrb,
    input  s_rdata, s_ready, s_err,
    input  m_valid, m_address, m_wdata, m_wstrb,
    output m_rdata, m_ready
  );

endinterface
`default_nettype wire

// File: rtl/clint_arbiter_rr_pick.sv
`default_nettype none
// rr_pick -- combinational round-robin picker: first requester at or after ptr wins (rev 1.0)
module rr_pick
  import clint_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req_i,
  input  wire logic [IDX_W-1:0] ptr_i,
  output logic      [N_REQ-1:0] grant_o,
  output logic      [IDX_W-1:0] idx_o,
  output logic                  any_o
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    // rot[i] is the request of requester (ptr + i) mod N_REQ
    rot = N_REQ'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    idx_o   = sum[IDX_W-1:0];
    any_o   = |req_i;
    grant_o = any_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/clint_arbiter.sv
`default_nettype none
// clint_arbiter -- round-robin arbiter sharing one CLINT port among N_REQ hart buses,
// with a per-transaction timeout that aborts with all-ones data and an error pulse (rev 1.0)
module clint_arbiter
  import clint_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = CLINT_TIMEOUT_DEFAULT
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  clint_arbiter_if.slave bus
);

  localparam int               IDX_W    = idx_width(N_REQ);
  localparam int               STRB_W   = DATA_W / 8;
  localparam logic [15:0]      TO_LIMIT = 16'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]        gnt_oh_q, gnt_oh_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]       m_address_q, m_address_d;
  logic [DATA_W-1:0]       m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]       m_wstrb_q, m_wstrb_d;
  logic [N_REQ-1:0]        s_ready_q, s_ready_d;
  logic [N_REQ-1:0]        s_err_q, s_err_d;
  logic [N_REQ*DATA_W-1:0] s_rdata_q, s_rdata_d;

  logic [N_REQ-1:0]        pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [IDX_W-1:0]        ptr_next;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (bus.s_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign ptr_next = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    s_ready_d   = '0;
    s_err_d     = '0;
    s_rdata_d   = s_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_oh_d    = pick_oh;
          m_address_d = bus.s_address[pick_idx*ADDR_W +: ADDR_W];
          m_wdata_d   = bus.s_wdata[pick_idx*DATA_W +: DATA_W];
          m_wstrb_d   = bus.s_wstrb[pick_idx*STRB_W +: STRB_W];
          m_valid_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A response landing on the final counted cycle beats the abort
        if (bus.m_ready) begin
          s_rdata_d[gnt_idx_q*DATA_W +: DATA_W] = bus.m_rdata;
          s_ready_d = gnt_oh_q;
          m_valid_d = 1'b0;
          ptr_d     = ptr_next;
          state_d   = RESP;
        end else if (cnt_q + 16'd1 >= TO_LIMIT) begin
          s_rdata_d[gnt_idx_q*DATA_W +: DATA_W] = {DATA_W{1'b1}};
          s_ready_d = gnt_oh_q;
          s_err_d   = gnt_oh_q;
          m_valid_d = 1'b0;
          cnt_d     = cnt_q + 16'd1;
          ptr_d     = ptr_next;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      s_ready_q   <= '0;
      s_err_q     <= '0;
      s_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      s_ready_q   <= s_ready_d;
      s_err_q     <= s_err_d;
      s_rdata_q   <= s_rdata_d;
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_address = m_address_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wstrb   = m_wstrb_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.s_err     = s_err_q;
  assign bus.s_rdata   = s_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_arbiter.sv
`default_nettype none
// tb_clint_arbiter -- directed bench with a transaction-level model checked every cycle (rev 1.0)
module tb_clint_arbiter;
  import clint_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  clint_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(N)) bus ();

  clint_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: round-robin pointer, expected outputs, per-requester read data
  int            mptr;
  logic          exp_mv;
  logic [AW-1:0] exp_ma;
  logic [DW-1:0] exp_mw;
  logic [SW-1:0] exp_ms;
  logic [N-1:0]  exp_sr, exp_se;
  logic [N*DW-1:0] rexp;

  // Observations from the latest transaction, for literal pins
  int            obs_g;
  logic          obs_mv1;
  logic [AW-1:0] obs_ma;
  logic [DW-1:0] obs_mw;
  logic [SW-1:0] obs_ms;
  logic [N-1:0]  obs_sr, obs_se;
  logic [DW-1:0] obs_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (((m >> ((mptr + k) % N)) & 1) != 0) return (mptr + k) % N;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", bus.m_valid, exp_mv);
      if (exp_mv) begin
        chk("m_address", bus.m_address, exp_ma);
        chk("m_wdata", bus.m_wdata, exp_mw);
        chk("m_wstrb", bus.m_wstrb, exp_ms);
      end
      chk("s_ready", bus.s_ready, exp_sr);
      chk("s_err", bus.s_err, exp_se);
      chk("s_rdata", bus.s_rdata, rexp);
    end
  end

  // Starts in an IDLE cycle just after a rising edge; ready_after=k raises
  // m_ready in the k-th ISSUE cycle, 0 means the CLINT never answers.
  task automatic txn(input logic [N-1:0] vmask, input int ready_after, input logic [DW-1:0] resp);
    int g;
    logic [N-1:0] oh;
    bit done;
    g      = pick(vmask);
    obs_g  = g;
    oh     = N'(1) << g;
    exp_ma = bus.s_address[g*AW +: AW];
    exp_mw = bus.s_wdata[g*DW +: DW];
    exp_ms = bus.s_wstrb[g*SW +: SW];
    bus.s_valid = vmask;
    @(posedge clk); #1;
    exp_mv = 1'b1;
    bus.s_address = {$urandom, $urandom};
    bus.s_wdata   = {$urandom, $urandom};
    bus.s_wstrb   = 8'($urandom);
    bus.s_valid   = 2'($urandom);
    done = 1'b0;
    for (int k = 1; k <= TO && !done; k++) begin
      bus.m_ready = (k == ready_after);
      bus.m_rdata = (k == ready_after) ? resp : $urandom;
      if (k == 1) begin
        @(negedge clk);
        obs_mv1 = bus.m_valid;
        obs_ma  = bus.m_address;
        obs_mw  = bus.m_wdata;
        obs_ms  = bus.m_wstrb;
      end
      @(posedge clk); #1;
      if (k == ready_after || k == TO) begin
        done   = 1'b1;
        exp_mv = 1'b0;
        exp_sr = oh;
        exp_se = (k == ready_after) ? '0 : oh;
        rexp[g*DW +: DW] = (k == ready_after) ? resp : {DW{1'b1}};
        mptr = (g + 1) % N;
      end
    end
    // Stray activity in the response cycle must be ignored
    bus.m_ready = 1'b1;
    bus.m_rdata = $urandom;
    bus.s_valid = 2'($urandom);
    @(negedge clk);
    obs_sr = bus.s_ready;
    obs_se = bus.s_err;
    obs_rd = bus.s_rdata[g*DW +: DW];
    @(posedge clk); #1;
    exp_sr = '0;
    exp_se = '0;
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
  endtask

  initial begin
    bus.s_valid = '0; bus.s_address = '0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    mptr = 0; rexp = '0;
    exp_mv = 1'b0; exp_ma = '0; exp_mw = '0; exp_ms = '0; exp_sr = '0; exp_se = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst m_address", bus.m_address, 64'h0);
    chk("rst m_wdata", bus.m_wdata, 64'h0);
    chk("rst m_wstrb", bus.m_wstrb, 64'h0);
    chk("rst s_rdata", bus.s_rdata, 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters held: grants alternate 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      bus.s_address = {MTIMECMP_BASE + 32'h8, MTIMECMP_BASE};
      bus.s_wdata = '0;
      bus.s_wstrb = '0;
      txn(2'b11, 2, 32'hA0 + 32'(t));
      chk("rr grant", obs_g, 64'(t % 2));
      chk("rr s_ready", obs_sr, (t % 2 == 1) ? 64'h2 : 64'h1);
      chk("rr rdata", obs_rd, 64'hA0 + 64'(t));
    end

    // Write from requester 1 to MSIP+4
    bus.s_address = {MSIP_BASE + 32'h4, 32'h1111_0000};
    bus.s_wdata   = {32'h1, 32'hFFFF_0000};
    bus.s_wstrb   = 8'hF3;
    txn(2'b10, 3, 32'h0BAD_F00D);
    chk("wr m_address", obs_ma, 64'h4);
    chk("wr m_wdata", obs_mw, 64'h1);
    chk("wr m_wstrb", obs_ms, 64'hF);
    chk("wr s_ready", obs_sr, 64'h2);
    chk("wr rdata", obs_rd, 64'h0BAD_F00D);

    // Requester 0 reads mtime, CLINT answers in the third ISSUE cycle
    bus.s_address = {32'h0, MTIME_BASE};
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    txn(2'b01, 3, 32'h1234_5678);
    chk("rd m_valid t+1", obs_mv1, 64'h1);
    chk("rd m_address", obs_ma, 64'hBFF8);
    chk("rd s_ready", obs_sr, 64'h1);
    chk("rd s_err", obs_se, 64'h0);
    chk("rd rdata", obs_rd, 64'h1234_5678);

    // Pointer now at 1: a double request goes to requester 1
    bus.s_address = {MSIP_BASE, MSIP_BASE + 32'h4};
    txn(2'b11, 1, 32'h55);
    chk("ptr1 s_ready", obs_sr, 64'h2);

    // CLINT silent: abort after TIMEOUT ISSUE cycles
    bus.s_address = {32'h0, MTIMECMP_BASE};
    txn(2'b01, 0, 32'h0);
    chk("to s_ready", obs_sr, 64'h1);
    chk("to s_err", obs_se, 64'h1);
    chk("to rdata", obs_rd, 64'hFFFF_FFFF);

    // Response on the very cycle the counter expires wins
    bus.s_address = {MTIME_BASE, 32'h0};
    txn(2'b10, TO, 32'hCAFE_0036);
    chk("edge s_ready", obs_sr, 64'h2);
    chk("edge s_err", obs_se, 64'h0);
    chk("edge rdata", obs_rd, 64'hCAFE_0036);

    bus.s_address = {32'h0, MSIP_BASE};
    txn(2'b01, 1, 32'h77);

    // Reset in ISSUE, late m_ready after release is ignored
    bus.s_address = {MTIME_BASE, 32'h0};
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    exp_ma = MTIME_BASE; exp_mw = '0; exp_ms = '0;
    bus.s_valid = 2'b10;
    @(posedge clk); #1;
    exp_mv = 1'b1;
    bus.s_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    exp_mv = 1'b0; rexp = '0; mptr = 0;
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("abort s_ready", bus.s_ready, 64'h0);
    chk("abort m_valid", bus.m_valid, 64'h0);
    chk("abort s_rdata", bus.s_rdata, 64'h0);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    bus.s_address = {MSIP_BASE + 32'h4, MSIP_BASE};
    txn(2'b11, 1, 32'h99);
    chk("post-rst ptr0", obs_sr, 64'h1);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clint_arbiter.md
CLINT_ARBITER -- requirements
Module: clint_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of every port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; wstrb width is DATA_W/8.
REQ-003 SHALL have parameter N_REQ, default 2, meaning number of requesters (hart buses) sharing one CLINT port; legal range 1..16.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for m_ready before aborting; legal range 1..65535.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 s_valid  input  N_REQ  per-requester request.
REQ-008 s_address  input  N_REQ*ADDR_W  per-requester address; requester r occupies slice [r*ADDR_W +: ADDR_W].
REQ-009 s_wdata  input  N_REQ*DATA_W  per-requester write data, sliced the same way.
REQ-010 s_wstrb  input  N_REQ*DATA_W/8  per-requester strobe, sliced the same way.
REQ-011 s_rdata  output  N_REQ*DATA_W  per-requester read data.
REQ-012 s_ready  output  N_REQ  per-requester completion pulse.
REQ-013 s_err  output  N_REQ  per-requester timeout-abort pulse, coincident with s_ready.
REQ-014 m_valid, m_address, m_wdata, m_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  request to the CLINT.
REQ-015 m_rdata, m_ready  input  DATA_W/1  response from the CLINT.

Function
REQ-016 SHALL use a state machine with states IDLE, ISSUE and RESP.
- IDLE: when any s_valid bit is 1, grant one requester, latch its address/wdata/wstrb, and go to ISSUE.
- ISSUE: hold m_valid=1 with the latched fields.
- RESP: lasts exactly one cycle, then returns to IDLE.
REQ-017 Grant SHALL be round-robin.
- Search starts at ptr, ptr+1, ..., wrapping modulo N_REQ.
- After each completion, ptr SHALL become grant+1 mod N_REQ.
REQ-018 Latency: s_valid high in cycle t (state IDLE) SHALL give m_valid=1 from cycle t+1.
REQ-019 In ISSUE, m_ready=1 in cycle u SHALL capture m_rdata and move to RESP.
- In cycle u+1: s_ready[grant]=1 and s_rdata slice[grant]=captured data; all other s_ready bits are 0.
- m_valid SHALL be 0 from cycle u+1.
REQ-020 Writes (s_wstrb all ones) SHALL be passed through unchanged; s_rdata for a write SHALL carry whatever m_rdata returned.
REQ-021 The latched request SHALL NOT change while in ISSUE, even if s_* inputs change.
REQ-022 Requesters SHALL hold s_valid until s_ready; a requester that drops s_valid while granted SHALL still complete, and its response SHALL be delivered anyway.
REQ-023 Timeout counter:
- 16 bits, cleared on entry to ISSUE, incremented each ISSUE cycle with m_ready=0.
- On reaching TIMEOUT: go to RESP with s_rdata slice = all ones, s_ready[grant]=1 and s_err[grant]=1 for one cycle, and advance ptr.
REQ-024 If m_ready=1 in the same cycle the counter reaches TIMEOUT, m_ready SHALL win: normal completion, s_err=0.
REQ-025 s_valid bits arriving during ISSUE/RESP SHALL be ignored until IDLE; a requester waits at most N_REQ-1 transactions.
REQ-026 m_ready seen in IDLE or RESP SHALL be ignored.
REQ-027 All outputs SHALL be registered; no combinational path from s_* to m_* or from m_* to s_*.
REQ-028 s_rdata slices of non-granted requesters SHALL hold their previous values.

Reset
REQ-029 With reset_n=0 at a rising edge:
- state=IDLE, ptr=0, timeout counter=0, m_valid=0.
- m_address, m_wdata, m_wstrb = 0; s_ready=0, s_err=0, s_rdata=0.
REQ-030 Reset mid-transaction SHALL abort it: no s_ready pulse follows, and a late m_ready after reset is ignored (state IDLE).

Structure
REQ-031 Package clint_pkg SHALL hold:
- the state enum (IDLE, ISSUE, RESP);
- CLINT_TIMEOUT_DEFAULT=255;
- the CLINT register offsets MSIP_BASE=0x0000, MTIMECMP_BASE=0x4000, MTIME_BASE=0xBFF8, for bench use.
REQ-032 Sub-module rr_pick SHALL be a combinational round-robin picker (req, ptr -> one-hot grant, index, any).

Verification
REQ-033 N_REQ=2, only req0 reads 0xBFF8, CLINT answers m_ready after 3 cycles with 0x12345678 -> m_valid at t+1; s_ready[0] and s_rdata[0]=0x12345678 exactly one cycle after m_ready; ptr=1.
REQ-034 req0 and req1 request simultaneously, both held, for 4 transactions -> grants 0,1,0,1; m_valid never overlaps two grants.
REQ-035 CLINT never asserts m_ready, TIMEOUT=4 -> s_ready[grant]=s_err[grant]=1 after 4 ISSUE cycles, s_rdata=0xFFFFFFFF, then IDLE.
REQ-036 m_ready arrives on the exact TIMEOUT cycle -> normal data returned, s_err=0.
REQ-037 reset_n=0 in ISSUE, m_ready=1 the cycle after reset release -> no s_ready pulse, m_valid=0, ptr=0.
REQ-038 Write 0x1 with wstrb=0xF from req1 to 0x0004 -> m_address=0x0004, m_wdata=0x1, m_wstrb=0xF held until m_ready, then s_ready[1]=1.
